// File: rtl/dual_issue_sched.sv
// Dual-issue scheduler: decides whether a decoded instruction pair issues together,
// splits across two cycles, or bubbles behind an outstanding load.
`ifndef RF_ADDR_WIDTH
`define RF_ADDR_WIDTH 5
`endif

module dual_issue_sched #(
  parameter int RF_ADDR_WIDTH = `RF_ADDR_WIDTH,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     ex_ready,
  input  logic                     id_valid0,
  input  logic [RF_ADDR_WIDTH-1:0] id_rd0,
  input  logic                     id_RdWrtEn0,
  input  logic                     id_LdEn0,
  input  logic                     id_MemEn0,
  input  logic [RF_ADDR_WIDTH-1:0] id_rs1_0,
  input  logic [RF_ADDR_WIDTH-1:0] id_rs2_0,
  input  logic                     id_valid1,
  input  logic [RF_ADDR_WIDTH-1:0] id_rd1,
  input  logic                     id_RdWrtEn1,
  input  logic                     id_LdEn1,
  input  logic                     id_MemEn1,
  input  logic [RF_ADDR_WIDTH-1:0] id_rs1_1,
  input  logic [RF_ADDR_WIDTH-1:0] id_rs2_1,
  output logic                     issue0_fire,
  output logic                     issue1_fire,
  output logic                     id_ready,
  output logic                     fwd1_rs1_en,
  output logic                     fwd1_rs2_en,
  output logic [1:0]               sched_state,
  output logic [CNT_WIDTH-1:0]     split_cnt,
  output logic [CNT_WIDTH-1:0]     bubble_cnt
);

  typedef enum logic [1:0] {
    PAIR  = 2'd0,
    HOLD1 = 2'd1
  } state_e;

  state_e                   state_q, state_d;
  logic                     ld_pend_q, ld_pend_d;
  logic [RF_ADDR_WIDTH-1:0] ld_rd_q, ld_rd_d;
  logic [CNT_WIDTH-1:0]     split_cnt_q, split_cnt_d;
  logic [CNT_WIDTH-1:0]     bubble_cnt_q, bubble_cnt_d;

  logic in_hold;
  logic slot1_valid;
  logic ldhaz0, ldhaz1;
  logic raw01, raw01_rs1, raw01_rs2;
  logic split;
  logic split_inc, bubble_inc;

  // Any encoding other than HOLD1 behaves as PAIR.
  assign in_hold     = (state_q == HOLD1);
  assign slot1_valid = id_valid0 & id_valid1;

  assign ldhaz0 = ld_pend_q &
                  (((id_rs1_0 != '0) && (id_rs1_0 == ld_rd_q)) ||
                   ((id_rs2_0 != '0) && (id_rs2_0 == ld_rd_q)));
  assign ldhaz1 = ld_pend_q &
                  (((id_rs1_1 != '0) && (id_rs1_1 == ld_rd_q)) ||
                   ((id_rs2_1 != '0) && (id_rs2_1 == ld_rd_q)));

  assign raw01_rs1 = id_RdWrtEn0 && (id_rd0 != '0) && (id_rd0 == id_rs1_1);
  assign raw01_rs2 = id_RdWrtEn0 && (id_rd0 != '0) && (id_rd0 == id_rs2_1);
  assign raw01     = raw01_rs1 | raw01_rs2;
  assign split     = (raw01 & id_LdEn0) | (id_MemEn0 & id_MemEn1);

  always_comb begin
    issue0_fire  = 1'b0;
    issue1_fire  = 1'b0;
    id_ready     = 1'b0;
    fwd1_rs1_en  = 1'b0;
    fwd1_rs2_en  = 1'b0;
    split_inc    = 1'b0;
    bubble_inc   = 1'b0;
    state_d      = state_q;
    ld_pend_d    = ld_pend_q;
    ld_rd_d      = ld_rd_q;

    if (!rst_n) begin
      state_d = PAIR;
    end else if (flush) begin
      state_d   = PAIR;
      ld_pend_d = 1'b0;
    end else if (ex_ready) begin
      if (in_hold) begin
        if (ldhaz1) begin
          bubble_inc = 1'b1;
        end else begin
          issue1_fire = 1'b1;
          id_ready    = 1'b1;
          state_d     = PAIR;
        end
      end else if (!id_valid0) begin
        id_ready = 1'b1;
      end else if (ldhaz0 || (slot1_valid && ldhaz1)) begin
        bubble_inc = 1'b1;
      end else if (!slot1_valid) begin
        issue0_fire = 1'b1;
        id_ready    = 1'b1;
      end else if (split) begin
        issue0_fire = 1'b1;
        split_inc   = 1'b1;
        state_d     = HOLD1;
      end else begin
        issue0_fire = 1'b1;
        issue1_fire = 1'b1;
        id_ready    = 1'b1;
        fwd1_rs1_en = raw01_rs1;
        fwd1_rs2_en = raw01_rs2;
      end

      // Only the youngest fired load is tracked; a pair of loads always splits.
      ld_pend_d = 1'b0;
      if (issue1_fire && id_LdEn1 && id_RdWrtEn1 && (id_rd1 != '0)) begin
        ld_pend_d = 1'b1;
        ld_rd_d   = id_rd1;
      end else if (issue0_fire && id_LdEn0 && id_RdWrtEn0 && (id_rd0 != '0)) begin
        ld_pend_d = 1'b1;
        ld_rd_d   = id_rd0;
      end
    end

    split_cnt_d  = (split_inc && (split_cnt_q != '1)) ?
                   split_cnt_q + CNT_WIDTH'(1) : split_cnt_q;
    bubble_cnt_d = (bubble_inc && (bubble_cnt_q != '1)) ?
                   bubble_cnt_q + CNT_WIDTH'(1) : bubble_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= PAIR;
      ld_pend_q    <= 1'b0;
      ld_rd_q      <= '0;
      split_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      ld_pend_q    <= ld_pend_d;
      ld_rd_q      <= ld_rd_d;
      split_cnt_q  <= split_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign sched_state = state_q;
  assign split_cnt   = split_cnt_q;
  assign bubble_cnt  = bubble_cnt_q;

endmodule

// File: tb/tb_dual_issue_sched.sv
// Testbench for dual_issue_sched: directed scenarios plus randomized pairs
// checked against a rule-level reference model.
module tb_dual_issue_sched;

  localparam int AW    = 5;
  localparam int CW    = 4;
  localparam int CMAX  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n, flush, ex_ready;
  logic          id_valid0, id_RdWrtEn0, id_LdEn0, id_MemEn0;
  logic [AW-1:0] id_rd0, id_rs1_0, id_rs2_0;
  logic          id_valid1, id_RdWrtEn1, id_LdEn1, id_MemEn1;
  logic [AW-1:0] id_rd1, id_rs1_1, id_rs2_1;
  logic          issue0_fire, issue1_fire, id_ready, fwd1_rs1_en, fwd1_rs2_en;
  logic [1:0]    sched_state;
  logic [CW-1:0] split_cnt, bubble_cnt;

  int total = 0;
  int bad   = 0;

  // Reference model state
  bit          m_hold = 0;
  bit          m_ldp  = 0;
  logic [AW-1:0] m_ldrd = '0;
  int          m_split = 0;
  int          m_bub   = 0;
  // Expected outputs for the current cycle
  bit e_i0, e_i1, e_rdy, e_f1, e_f2, e_bub, e_spl, e_next_hold;

  dual_issue_sched #(.RF_ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .ex_ready(ex_ready),
    .id_valid0(id_valid0), .id_rd0(id_rd0), .id_RdWrtEn0(id_RdWrtEn0),
    .id_LdEn0(id_LdEn0), .id_MemEn0(id_MemEn0), .id_rs1_0(id_rs1_0), .id_rs2_0(id_rs2_0),
    .id_valid1(id_valid1), .id_rd1(id_rd1), .id_RdWrtEn1(id_RdWrtEn1),
    .id_LdEn1(id_LdEn1), .id_MemEn1(id_MemEn1), .id_rs1_1(id_rs1_1), .id_rs2_1(id_rs2_1),
    .issue0_fire(issue0_fire), .issue1_fire(issue1_fire), .id_ready(id_ready),
    .fwd1_rs1_en(fwd1_rs1_en), .fwd1_rs2_en(fwd1_rs2_en), .sched_state(sched_state),
    .split_cnt(split_cnt), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  function automatic bit reads_load(input logic [AW-1:0] a, input logic [AW-1:0] b);
    return m_ldp && ((a != 0 && a == m_ldrd) || (b != 0 && b == m_ldrd));
  endfunction

  // Decide what should happen this cycle from the scheduling rules.
  function automatic void model_eval();
    bit dep;
    e_i0 = 0; e_i1 = 0; e_rdy = 0; e_f1 = 0; e_f2 = 0; e_bub = 0; e_spl = 0;
    e_next_hold = m_hold;
    if (rst_n && !flush && ex_ready) begin
      if (m_hold) begin
        if (reads_load(id_rs1_1, id_rs2_1)) e_bub = 1;
        else begin e_i1 = 1; e_rdy = 1; e_next_hold = 0; end
      end else if (!id_valid0) begin
        e_rdy = 1;
      end else begin
        dep = id_RdWrtEn0 && id_rd0 != 0 && (id_rd0 == id_rs1_1 || id_rd0 == id_rs2_1);
        if (reads_load(id_rs1_0, id_rs2_0) || (id_valid1 && reads_load(id_rs1_1, id_rs2_1)))
          e_bub = 1;
        else if (!id_valid1) begin
          e_i0 = 1; e_rdy = 1;
        end else if ((dep && id_LdEn0) || (id_MemEn0 && id_MemEn1)) begin
          e_i0 = 1; e_spl = 1; e_next_hold = 1;
        end else begin
          e_i0 = 1; e_i1 = 1; e_rdy = 1;
          e_f1 = dep && (id_rd0 == id_rs1_1);
          e_f2 = dep && (id_rd0 == id_rs2_1);
        end
      end
    end
  endfunction

  function automatic void model_commit();
    if (!rst_n) begin
      m_hold = 0; m_ldp = 0; m_ldrd = '0; m_split = 0; m_bub = 0;
    end else if (flush) begin
      m_hold = 0; m_ldp = 0;
    end else if (ex_ready) begin
      m_hold = e_next_hold;
      if (e_spl && m_split < CMAX) m_split++;
      if (e_bub && m_bub < CMAX) m_bub++;
      m_ldp = 0;
      if (e_i1 && id_LdEn1 && id_RdWrtEn1 && id_rd1 != 0) begin
        m_ldp = 1; m_ldrd = id_rd1;
      end else if (e_i0 && id_LdEn0 && id_RdWrtEn0 && id_rd0 != 0) begin
        m_ldp = 1; m_ldrd = id_rd0;
      end
    end
  endfunction

  task automatic settle();
    @(negedge clk);
    model_eval();
  endtask

  task automatic tick();
    model_eval();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic set0(input bit v, input int rd, input bit wen, input bit ld,
                      input bit mem, input int rs1, input int rs2);
    id_valid0 = v; id_rd0 = AW'(rd); id_RdWrtEn0 = wen; id_LdEn0 = ld;
    id_MemEn0 = mem; id_rs1_0 = AW'(rs1); id_rs2_0 = AW'(rs2);
  endtask

  task automatic set1(input bit v, input int rd, input bit wen, input bit ld,
                      input bit mem, input int rs1, input int rs2);
    id_valid1 = v; id_rd1 = AW'(rd); id_RdWrtEn1 = wen; id_LdEn1 = ld;
    id_MemEn1 = mem; id_rs1_1 = AW'(rs1); id_rs2_1 = AW'(rs2);
  endtask

  task automatic quiesce();
    flush = 1; tick(); flush = 0;
  endtask

  task automatic test_reset();
    rst_n = 0; flush = 0; ex_ready = 1;
    set0(1, 5, 1, 0, 0, 1, 2); set1(1, 6, 1, 0, 0, 5, 3);
    tick(); tick();
    settle();
    total++; if (issue0_fire !== 1'b0) begin bad++; $display("[TB] FAIL reset_i0 got=%0d exp=0", issue0_fire); end
    total++; if (issue1_fire !== 1'b0) begin bad++; $display("[TB] FAIL reset_i1 got=%0d exp=0", issue1_fire); end
    total++; if (id_ready !== 1'b0) begin bad++; $display("[TB] FAIL reset_rdy got=%0d exp=0", id_ready); end
    total++; if (fwd1_rs1_en !== 1'b0) begin bad++; $display("[TB] FAIL reset_fwd1 got=%0d exp=0", fwd1_rs1_en); end
    total++; if (sched_state !== 2'd0) begin bad++; $display("[TB] FAIL reset_state got=%0d exp=0", sched_state); end
    total++; if (split_cnt !== '0) begin bad++; $display("[TB] FAIL reset_split got=%0d exp=0", split_cnt); end
    total++; if (bubble_cnt !== '0) begin bad++; $display("[TB] FAIL reset_bubble got=%0d exp=0", bubble_cnt); end
    tick();
    rst_n = 1;
  endtask

  task automatic test_pair_forward();
    quiesce();
    set0(1, 5, 1, 0, 0, 1, 2); set1(1, 8, 1, 0, 0, 5, 6);
    settle();
    total++; if ({issue0_fire, issue1_fire} !== 2'b11) begin bad++; $display("[TB] FAIL pair_fire got=%b exp=11", {issue0_fire, issue1_fire}); end
    total++; if ({fwd1_rs1_en, fwd1_rs2_en} !== 2'b10) begin bad++; $display("[TB] FAIL pair_fwd got=%b exp=10", {fwd1_rs1_en, fwd1_rs2_en}); end
    total++; if (id_ready !== 1'b1) begin bad++; $display("[TB] FAIL pair_rdy got=%0d exp=1", id_ready); end
    tick();
  endtask

  task automatic test_valid1_only();
    quiesce();
    set0(0, 5, 1, 0, 0, 1, 2); set1(1, 8, 1, 0, 0, 3, 4);
    settle();
    total++; if ({issue0_fire, issue1_fire, id_ready} !== 3'b001) begin bad++; $display("[TB] FAIL v1only got=%b exp=001", {issue0_fire, issue1_fire, id_ready}); end
    tick();
  endtask

  task automatic test_load_split();
    int s0, b0;
    quiesce();
    s0 = m_split; b0 = m_bub;
    set0(1, 7, 1, 1, 1, 1, 2); set1(1, 8, 1, 0, 0, 3, 7);
    settle();
    total++; if ({issue0_fire, issue1_fire, id_ready} !== 3'b100) begin bad++; $display("[TB] FAIL lsplit_c0 got=%b exp=100", {issue0_fire, issue1_fire, id_ready}); end
    tick(); settle();
    total++; if (sched_state !== 2'd1) begin bad++; $display("[TB] FAIL lsplit_hold got=%0d exp=1", sched_state); end
    total++; if (int'(split_cnt) !== s0 + 1) begin bad++; $display("[TB] FAIL lsplit_cnt got=%0d exp=%0d", split_cnt, s0 + 1); end
    total++; if ({issue0_fire, issue1_fire, id_ready} !== 3'b000) begin bad++; $display("[TB] FAIL lsplit_c1 got=%b exp=000", {issue0_fire, issue1_fire, id_ready}); end
    tick(); settle();
    total++; if (int'(bubble_cnt) !== b0 + 1) begin bad++; $display("[TB] FAIL lsplit_bub got=%0d exp=%0d", bubble_cnt, b0 + 1); end
    total++; if ({issue0_fire, issue1_fire, id_ready} !== 3'b011) begin bad++; $display("[TB] FAIL lsplit_c2 got=%b exp=011", {issue0_fire, issue1_fire, id_ready}); end
    tick(); settle();
    total++; if (sched_state !== 2'd0) begin bad++; $display("[TB] FAIL lsplit_pair got=%0d exp=0", sched_state); end
  endtask

  task automatic test_structural();
    quiesce();
    set0(1, 0, 0, 0, 1, 1, 2); set1(1, 9, 1, 1, 1, 3, 4);
    settle();
    total++; if ({issue0_fire, issue1_fire} !== 2'b10) begin bad++; $display("[TB] FAIL struct_c0 got=%b exp=10", {issue0_fire, issue1_fire}); end
    tick(); settle();
    total++; if ({issue0_fire, issue1_fire, id_ready} !== 3'b011) begin bad++; $display("[TB] FAIL struct_c1 got=%b exp=011", {issue0_fire, issue1_fire, id_ready}); end
    tick();
    set0(1, 3, 1, 0, 0, 9, 0); set1(0, 0, 0, 0, 0, 0, 0);
    settle();
    total++; if ({issue0_fire, id_ready} !== 2'b00) begin bad++; $display("[TB] FAIL struct_ldpend got=%b exp=00", {issue0_fire, id_ready}); end
    tick(); settle();
    total++; if ({issue0_fire, id_ready} !== 2'b11) begin bad++; $display("[TB] FAIL struct_after got=%b exp=11", {issue0_fire, id_ready}); end
    tick();
  endtask

  task automatic test_stall_hold();
    int s0, b0;
    quiesce();
    set0(1, 0, 0, 0, 1, 1, 2); set1(1, 0, 0, 0, 1, 3, 4);
    tick();
    s0 = m_split; b0 = m_bub;
    ex_ready = 0;
    for (int k = 0; k < 3; k++) begin
      settle();
      total++; if ({issue0_fire, issue1_fire, id_ready} !== 3'b000) begin bad++; $display("[TB] FAIL stall_fire%0d got=%b exp=000", k, {issue0_fire, issue1_fire, id_ready}); end
      total++; if (sched_state !== 2'd1) begin bad++; $display("[TB] FAIL stall_state%0d got=%0d exp=1", k, sched_state); end
      total++; if (int'(split_cnt) !== s0 || int'(bubble_cnt) !== b0) begin bad++; $display("[TB] FAIL stall_cnt%0d got=%0d/%0d exp=%0d/%0d", k, split_cnt, bubble_cnt, s0, b0); end
      tick();
    end
    ex_ready = 1;
    settle();
    total++; if ({issue1_fire, id_ready} !== 2'b11) begin bad++; $display("[TB] FAIL stall_release got=%b exp=11", {issue1_fire, id_ready}); end
    tick();
  endtask

  task automatic test_flush_hold();
    int b0;
    quiesce();
    set0(1, 7, 1, 1, 1, 1, 2); set1(1, 8, 1, 0, 0, 7, 3);
    tick();
    b0 = m_bub;
    flush = 1;
    settle();
    total++; if ({issue0_fire, issue1_fire, id_ready} !== 3'b000) begin bad++; $display("[TB] FAIL flush_fire got=%b exp=000", {issue0_fire, issue1_fire, id_ready}); end
    tick();
    flush = 0;
    set0(1, 3, 1, 0, 0, 7, 0); set1(1, 4, 1, 0, 0, 3, 7);
    settle();
    total++; if (sched_state !== 2'd0) begin bad++; $display("[TB] FAIL flush_state got=%0d exp=0", sched_state); end
    total++; if ({issue0_fire, issue1_fire, fwd1_rs1_en} !== 3'b111) begin bad++; $display("[TB] FAIL flush_pair got=%b exp=111", {issue0_fire, issue1_fire, fwd1_rs1_en}); end
    tick(); settle();
    total++; if (int'(bubble_cnt) !== b0) begin bad++; $display("[TB] FAIL flush_bub got=%0d exp=%0d", bubble_cnt, b0); end
  endtask

  task automatic test_reset_in_hold();
    quiesce();
    set0(1, 0, 0, 0, 1, 1, 2); set1(1, 0, 0, 0, 1, 3, 4);
    tick();
    rst_n = 0;
    settle();
    total++; if ({issue0_fire, issue1_fire, id_ready} !== 3'b000) begin bad++; $display("[TB] FAIL rsthold_fire got=%b exp=000", {issue0_fire, issue1_fire, id_ready}); end
    tick();
    rst_n = 1;
    set0(1, 2, 1, 0, 0, 1, 1); set1(0, 0, 0, 0, 0, 0, 0);
    settle();
    total++; if ({sched_state, issue0_fire, issue1_fire} !== 4'b0010) begin bad++; $display("[TB] FAIL rsthold_after got=%b exp=0010", {sched_state, issue0_fire, issue1_fire}); end
    total++; if (split_cnt !== '0) begin bad++; $display("[TB] FAIL rsthold_cnt got=%0d exp=0", split_cnt); end
    tick();
  endtask

  task automatic test_saturate();
    quiesce();
    set0(1, 0, 0, 0, 1, 0, 0); set1(1, 0, 0, 0, 1, 0, 0);
    for (int k = 0; k < CMAX + 4; k++) begin tick(); tick(); end
    settle();
    total++; if (split_cnt !== CW'(CMAX)) begin bad++; $display("[TB] FAIL sat_split got=%0d exp=%0d", split_cnt, CMAX); end
    tick();
  endtask

  task automatic test_random();
    bit regen = 1;
    bit ld;
    for (int c = 0; c < 600; c++) begin
      rst_n    = ($urandom_range(0, 79) != 0);
      flush    = ($urandom_range(0, 15) == 0);
      ex_ready = ($urandom_range(0, 3) != 0);
      if (regen) begin
        ld = ($urandom_range(0, 3) == 0);
        set0($urandom_range(0, 7) != 0, $urandom_range(0, 3), ld | $urandom_range(0, 1),
             ld, ld | ($urandom_range(0, 3) == 0), $urandom_range(0, 3), $urandom_range(0, 3));
        ld = ($urandom_range(0, 3) == 0);
        set1($urandom_range(0, 3) != 0, $urandom_range(0, 3), ld | $urandom_range(0, 1),
             ld, ld | ($urandom_range(0, 3) == 0), $urandom_range(0, 3), $urandom_range(0, 3));
      end
      settle();
      total++; if (issue0_fire !== e_i0) begin bad++; $display("[TB] FAIL rnd_i0 c=%0d got=%0d exp=%0d", c, issue0_fire, e_i0); end
      total++; if (issue1_fire !== e_i1) begin bad++; $display("[TB] FAIL rnd_i1 c=%0d got=%0d exp=%0d", c, issue1_fire, e_i1); end
      total++; if (id_ready !== e_rdy) begin bad++; $display("[TB] FAIL rnd_rdy c=%0d got=%0d exp=%0d", c, id_ready, e_rdy); end
      total++; if ({fwd1_rs1_en, fwd1_rs2_en} !== {e_f1, e_f2}) begin bad++; $display("[TB] FAIL rnd_fwd c=%0d got=%b exp=%b", c, {fwd1_rs1_en, fwd1_rs2_en}, {e_f1, e_f2}); end
      total++; if (sched_state !== {1'b0, m_hold}) begin bad++; $display("[TB] FAIL rnd_state c=%0d got=%0d exp=%0d", c, sched_state, m_hold); end
      total++; if (int'(split_cnt) !== m_split) begin bad++; $display("[TB] FAIL rnd_split c=%0d got=%0d exp=%0d", c, split_cnt, m_split); end
      total++; if (int'(bubble_cnt) !== m_bub) begin bad++; $display("[TB] FAIL rnd_bub c=%0d got=%0d exp=%0d", c, bubble_cnt, m_bub); end
      // Decode advances only when the pair was consumed or the pipe was cleared.
      regen = e_rdy || flush || !rst_n;
      tick();
    end
    rst_n = 1; flush = 0; ex_ready = 1;
  endtask

  initial begin
    rst_n = 0; flush = 0; ex_ready = 1;
    set0(0, 0, 0, 0, 0, 0, 0); set1(0, 0, 0, 0, 0, 0, 0);
    test_reset();
    test_pair_forward();
    test_valid1_only();
    test_load_split();
    test_structural();
    test_stall_hold();
    test_flush_hold();
    test_reset_in_hold();
    test_saturate();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dual_issue_sched.md
DUAL_ISSUE_SCHED -- requirements
Module: dual_issue_sched

Interface
REQ-001 Parameter RF_ADDR_WIDTH, default `RF_ADDR_WIDTH (5), register-file address width.
REQ-002 Parameter CNT_WIDTH, default 16, performance-counter width.
REQ-003 Clock and reset SHALL be: one clock; reset is synchronous and active-low. Ports: clk input 1, rising-edge clock; rst_n input 1, synchronous active-low reset.
REQ-004 Control inputs, 1 bit each: flush (pipeline flush); ex_ready (EX can accept issue).
REQ-005 Slot-0 inputs: id_valid0 1; id_rd0 RF_ADDR_WIDTH; id_RdWrtEn0 1; id_LdEn0 1; id_MemEn0 1; id_rs1_0, id_rs2_0 RF_ADDR_WIDTH.
REQ-006 Slot-1 inputs: id_valid1 1; id_rd1 RF_ADDR_WIDTH; id_RdWrtEn1 1; id_LdEn1 1; id_MemEn1 1; id_rs1_1, id_rs2_1 RF_ADDR_WIDTH.
REQ-007 Outputs: issue0_fire 1; issue1_fire 1; id_ready 1 (decode pair consumed, may advance); fwd1_rs1_en 1, fwd1_rs2_en 1 (slot1 operand taken from slot0 result); sched_state 2; split_cnt CNT_WIDTH; bubble_cnt CNT_WIDTH.

Function
REQ-010 States SHALL be PAIR (2'd0) and HOLD1 (2'd1); sched_state shows the current state; 2'd2/2'd3 unused and SHALL decode as PAIR.
REQ-011 Load-pending register (ld_pend, ld_rd) SHALL be set on the cycle after a fired instruction with LdEn=1, RdWrtEn=1, rd!=0, capturing that rd; otherwise cleared. It SHALL never hold two loads.
REQ-012 ldhaz(slot) SHALL be true when ld_pend=1 and ld_rd equals that slot's nonzero rs1 or rs2.
REQ-013 raw01 SHALL be id_RdWrtEn0 & id_rd0!=0 & id_rd0 in {id_rs1_1, id_rs2_1}.
REQ-014 split SHALL be (raw01 & id_LdEn0) | (id_MemEn0 & id_MemEn1).
REQ-015 Slot 1 SHALL be valid only when id_valid0=1; id_valid1 alone SHALL be ignored.
REQ-016 All outputs except counters/state SHALL be combinational from state and inputs; zero added latency.
REQ-017 When rst_n=0, flush=1, or ex_ready=0: issue0_fire=issue1_fire=id_ready=fwd1_*=0. flush forces PAIR and clears ld_pend. ex_ready=0 holds all state.
REQ-018 PAIR, id_valid0=0: no fire, id_ready=1.
REQ-019 PAIR, ldhaz(slot0), or ldhaz(slot1) with slot1 valid: no fire, id_ready=0, bubble_cnt+1, stay PAIR.
REQ-020 PAIR, slot0 only valid, no hazard: issue0_fire=1, id_ready=1.
REQ-021 PAIR, both valid, split: issue0_fire=1, issue1_fire=0, id_ready=0, split_cnt+1, next HOLD1.
REQ-022 PAIR, both valid, no split: both fire, id_ready=1; fwd1_rs1_en=raw01 & id_rd0==id_rs1_1; fwd1_rs2_en similarly for rs2.
REQ-023 HOLD1: slot1 fields SHALL be read from id_* (decode holds them stable while id_ready=0); issue0_fire=0; fwd1_*=0.
REQ-024 HOLD1, ldhaz(slot1): no fire, id_ready=0, bubble_cnt+1, stay HOLD1.
REQ-025 HOLD1, no hazard: issue1_fire=1, id_ready=1, next PAIR.
REQ-026 Counters SHALL saturate at all-ones, SHALL NOT be cleared by flush, and increment only when ex_ready=1 and flush=0.
REQ-027 flush and a would-be fire in the same cycle: flush wins; nothing fires, counters unchanged.

Reset
REQ-030 On clk edge with rst_n=0: state=PAIR, ld_pend=0, ld_rd=0, split_cnt=0, bubble_cnt=0.
REQ-031 While rst_n=0 all fire/ready/forward outputs SHALL be 0 and sched_state=0.
REQ-032 Reset mid-HOLD1 SHALL abandon the held slot1 without issuing it.

Verification
REQ-040 Pair: slot0 ADD rd=5, slot1 SUB rs1=5, rs2=6 -> cycle0 both fire, fwd1_rs1_en=1, fwd1_rs2_en=0, id_ready=1.
REQ-041 Load split: slot0 LW rd=7, slot1 ADD rs2=7 -> c0 issue0_fire only, split_cnt=1, state=HOLD1; c1 ldhaz, no fire, bubble_cnt=1; c2 issue1_fire=1, id_ready=1, state=PAIR.
REQ-042 Structural: slot0 SW, slot1 LW rd=9 (independent) -> c0 issue0 only; c1 issue1 only; c2 ld_pend=1, ld_rd=9.
REQ-043 ex_ready=0 for 3 cycles in HOLD1 -> no fires, state HOLD1, counters frozen; on ex_ready=1 issue1_fire=1.
REQ-044 flush in HOLD1 with ld_pend=1 -> that cycle no fire; next cycle state=PAIR, dependent pair fires without bubble.
REQ-045 Force 2^CNT_WIDTH+3 splits -> split_cnt=all-ones, no wrap.
